// File: rtl/dqs_pattern_pkg.sv
// dqs_pattern_pkg: shared constants for the DQS preamble/postamble/interamble generator.
//   - Write FSM state codes as seen on i_fsm_state.
//   - Symbol patterns packed flat, symbol k at bits [2k+1:2k], symbol = {first half, second half}.
//   - Pattern lengths in tCK and a small helper deriving the interamble from a preamble.
package dqs_pattern_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_PRE   = 3'b001;
  localparam logic [2:0] ST_POST  = 3'b011;
  localparam logic [2:0] ST_INTER = 3'b100;
  localparam logic [2:0] ST_CRC   = 3'b111;

  localparam int unsigned MAX_SLOTS = 4;
  localparam int unsigned LEN_W     = 3;

  typedef logic [LEN_W-1:0]       len_t;
  typedef logic [2*MAX_SLOTS-1:0] pat_t;

  typedef struct packed {
    pat_t pat;
    len_t len;
  } pat_cfg_t;

  // Symbols listed last-to-first: {s3, s2, s1, s0}
  localparam pat_t PAT_PRE_2     = {2'b00, 2'b00, 2'b10, 2'b00};
  localparam pat_t PAT_PRE_3     = {2'b00, 2'b10, 2'b00, 2'b00};
  localparam pat_t PAT_PRE_4     = {2'b10, 2'b00, 2'b00, 2'b00};
  localparam pat_t PAT_POST_05   = {2'b00, 2'b00, 2'b00, 2'b00};
  localparam pat_t PAT_POST_15   = {2'b00, 2'b00, 2'b00, 2'b10};
  localparam pat_t PAT_INTER_OFF = {2'b00, 2'b00, 2'b00, 2'b00};

  localparam logic [1:0] SYM_INTER_FIRST = 2'b10;

  localparam len_t LEN_PRE_2     = 3'd2;
  localparam len_t LEN_PRE_3     = 3'd3;
  localparam len_t LEN_PRE_4     = 3'd4;
  localparam len_t LEN_POST_05   = 3'd1;
  localparam len_t LEN_POST_15   = 3'd2;
  localparam len_t LEN_INTER_OFF = 3'd1;

  function automatic pat_cfg_t post_cfg(input logic sel);
    pat_cfg_t r;
    r.pat = sel ? PAT_POST_15 : PAT_POST_05;
    r.len = sel ? LEN_POST_15 : LEN_POST_05;
    return r;
  endfunction

  // Interamble is the preamble with its first symbol replaced by 10; same length.
  function automatic pat_cfg_t inter_from_pre(input pat_cfg_t pre);
    pat_cfg_t r;
    r = pre;
    r.pat[1:0] = SYM_INTER_FIRST;
    return r;
  endfunction

endpackage

// File: rtl/dqs_sym_shifter.sv
// dqs_sym_shifter: loadable symbol register with a saturating symbol counter.
//   While i_active is low the pattern/length are loaded every enabled cycle and the counter
//   clears; while high the counter advances once per enabled cycle and saturates at len-1.
// Ports:
//   i_clk, i_rst (async, active-low), i_enable (low freezes all state)
//   i_active      - owning FSM state is current
//   i_pat, i_len  - pattern/length to capture while inactive
//   o_sym         - current symbol (00 when not valid)
//   o_valid       - active and counter < length
//   o_done        - active and counter == length-1
module dqs_sym_shifter
  import dqs_pattern_pkg::*;
#(
  parameter int unsigned        SLOTS   = 4,
  parameter logic [2*SLOTS-1:0] RST_PAT = '0,
  parameter len_t               RST_LEN = 3'd1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_active,
  input  logic [2*SLOTS-1:0] i_pat,
  input  len_t               i_len,
  output logic [1:0]         o_sym,
  output logic               o_valid,
  output logic               o_done
);

  localparam len_t LenOne = 3'd1;

  logic [2*SLOTS-1:0] pat_q, pat_d;
  len_t               len_q, len_d;
  len_t               cnt_q, cnt_d;
  len_t               last;

  assign last = len_q - LenOne;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    cnt_d = cnt_q;
    if (i_active) begin
      if (cnt_q != last) begin
        cnt_d = cnt_q + LenOne;
      end
    end else begin
      cnt_d = '0;
      pat_d = i_pat;
      len_d = i_len;
    end
  end

  always_comb begin
    o_valid = i_active && (cnt_q < len_q);
    o_done  = i_active && (cnt_q == last);
    o_sym   = 2'b00;
    if (o_valid) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (cnt_q == len_t'(i)) begin
          o_sym = pat_q[2*i +: 2];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pat_q <= RST_PAT;
      len_q <= RST_LEN;
      cnt_q <= '0;
    end else if (i_enable) begin
      pat_q <= pat_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dqs_pattern_gen.sv
// dqs_pattern_gen: DQS preamble / postamble / interamble symbol generator for the write path.
//   Selects are latched in idle, postamble and crc states and frozen otherwise; each pattern
//   is played from symbol 0 starting in the first cycle of its FSM state (zero latency).
//   The postamble shares the o_preamble_bits lane (state 011); o_preamble_valid covers 001 only.
// Configuration:
//   DQS_PRE_4TCK_EN - when defined, preamble select 10 gives the 4tCK pattern; otherwise it
//                     falls back to 2tCK and symbol storage shrinks to 3 slots.
// Ports:
//   i_clk, i_rst (async, active-low), i_enable (low freezes all state)
//   i_fsm_state, i_interamble_valid, i_preamble_sel, i_postamble_sel - write FSM inputs
//   o_preamble_bits, o_preamble_valid, o_preamble_done, o_postamble_done
//   o_interamble_bits, o_interamble_done
module dqs_pattern_gen
  import dqs_pattern_pkg::*;
#(
  parameter int unsigned PRE_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [2:0] i_fsm_state,
  input  logic       i_interamble_valid,
  input  logic [1:0] i_preamble_sel,
  input  logic       i_postamble_sel,
  output logic [1:0] o_preamble_bits,
  output logic       o_preamble_valid,
  output logic       o_preamble_done,
  output logic       o_postamble_done,
  output logic       o_interamble_done,
  output logic [1:0] o_interamble_bits
);

`ifdef DQS_PRE_4TCK_EN
  localparam int unsigned Slots = PRE_MAX;
`else
  localparam int unsigned Slots = (PRE_MAX > 3) ? 3 : PRE_MAX;
`endif

  function automatic pat_cfg_t pre_cfg(input logic [1:0] sel);
    pat_cfg_t r;
    r.pat = PAT_PRE_2;
    r.len = LEN_PRE_2;
    case (sel)
      2'b01: begin
        r.pat = PAT_PRE_3;
        r.len = LEN_PRE_3;
      end
`ifdef DQS_PRE_4TCK_EN
      2'b10: begin
        r.pat = PAT_PRE_4;
        r.len = LEN_PRE_4;
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

  logic [1:0] pre_sel_q, pre_sel_d;
  logic       post_sel_q, post_sel_d;
  logic       arm_q, arm_d;
  logic       sel_latch;

  pat_cfg_t pre_cfg_d, post_cfg_d, inter_cfg_d;

  logic       st_pre, st_post, st_inter;
  logic [1:0] pre_sym, post_sym, inter_sym;
  logic       pre_valid, post_valid, inter_valid;
  logic       pre_done, post_done, inter_done;
  logic       unused_sink;

  assign st_pre   = (i_fsm_state == ST_PRE);
  assign st_post  = (i_fsm_state == ST_POST);
  assign st_inter = (i_fsm_state == ST_INTER);

  assign sel_latch = (i_fsm_state == ST_IDLE) || st_post || (i_fsm_state == ST_CRC);

  always_comb begin
    pre_sel_d  = sel_latch ? i_preamble_sel  : pre_sel_q;
    post_sel_d = sel_latch ? i_postamble_sel : post_sel_q;
    // The interamble shifter has captured its pattern before state 100 is entered, so
    // dropping the arm during 100 is equivalent to clearing it on exit.
    arm_d = arm_q;
    if ((i_fsm_state == ST_CRC) && i_interamble_valid) begin
      arm_d = 1'b1;
    end else if (st_inter) begin
      arm_d = 1'b0;
    end
  end

  // Shifters load from the next-state selects so a pattern latched in the cycle before
  // entry is already playing in the first cycle of the state.
  always_comb begin
    pre_cfg_d   = pre_cfg(pre_sel_d);
    post_cfg_d  = post_cfg(post_sel_d);
    inter_cfg_d = arm_d ? inter_from_pre(pre_cfg_d) : '{pat: PAT_INTER_OFF, len: LEN_INTER_OFF};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pre_sel_q  <= 2'b00;
      post_sel_q <= 1'b0;
      arm_q      <= 1'b0;
    end else if (i_enable) begin
      pre_sel_q  <= pre_sel_d;
      post_sel_q <= post_sel_d;
      arm_q      <= arm_d;
    end
  end

  dqs_sym_shifter #(
    .SLOTS   (Slots),
    .RST_PAT (PAT_PRE_2[2*Slots-1:0]),
    .RST_LEN (LEN_PRE_2)
  ) u_pre (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_active (st_pre),
    .i_pat    (pre_cfg_d.pat[2*Slots-1:0]),
    .i_len    (pre_cfg_d.len),
    .o_sym    (pre_sym),
    .o_valid  (pre_valid),
    .o_done   (pre_done)
  );

  dqs_sym_shifter #(
    .SLOTS   (Slots),
    .RST_PAT (PAT_POST_05[2*Slots-1:0]),
    .RST_LEN (LEN_POST_05)
  ) u_post (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_active (st_post),
    .i_pat    (post_cfg_d.pat[2*Slots-1:0]),
    .i_len    (post_cfg_d.len),
    .o_sym    (post_sym),
    .o_valid  (post_valid),
    .o_done   (post_done)
  );

  dqs_sym_shifter #(
    .SLOTS   (Slots),
    .RST_PAT (PAT_INTER_OFF[2*Slots-1:0]),
    .RST_LEN (LEN_INTER_OFF)
  ) u_inter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_active (st_inter),
    .i_pat    (inter_cfg_d.pat[2*Slots-1:0]),
    .i_len    (inter_cfg_d.len),
    .o_sym    (inter_sym),
    .o_valid  (inter_valid),
    .o_done   (inter_done)
  );

  // Outputs are forced low while reset is asserted, independent of i_fsm_state.
  always_comb begin
    o_preamble_bits   = i_rst ? (pre_sym | post_sym) : 2'b00;
    o_preamble_valid  = i_rst & pre_valid;
    o_preamble_done   = i_rst & pre_done;
    o_postamble_done  = i_rst & post_done;
    o_interamble_done = i_rst & inter_done;
    o_interamble_bits = i_rst ? inter_sym : 2'b00;
  end

  // Pattern bits beyond the configured slot count and the secondary valids are not needed.
  assign unused_sink = ^{post_valid, inter_valid, pre_cfg_d, post_cfg_d, inter_cfg_d};

endmodule

// File: doc/dqs_pattern_gen.md
DQS_PATTERN_GEN -- requirements
Module: dqs_pattern_gen

Interface
REQ-001 SHALL have parameter PRE_MAX, default 4, meaning maximum preamble length in tCK (symbol slots per pattern register).
REQ-002 SHALL have port i_clk, input, 1, phy clock, all logic on rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port i_enable, input, 1, block enable; low freezes all registers.
REQ-005 SHALL have port i_fsm_state, input, 3, write FSM state code (000 idle, 001 preamble, 011 postamble, 100 interamble, 111 crc).
REQ-006 SHALL have port i_interamble_valid, input, 1, arm strobe from write FSM, high in crc and interamble states.
REQ-007 SHALL have port i_preamble_sel, input, 2, preamble length select (00 2tCK, 01 3tCK, 10 4tCK, 11 reserved).
REQ-008 SHALL have port i_postamble_sel, input, 1, postamble select (0 0.5tCK, 1 1.5tCK).
REQ-009 SHALL have output o_preamble_bits, 2, current DQS preamble symbol {first half, second half}.
REQ-010 SHALL have output o_preamble_valid, 1, high while a legal preamble symbol is driven.
REQ-011 SHALL have outputs o_preamble_done, o_postamble_done, o_interamble_done, 1 each, last-symbol indicators.
REQ-012 SHALL have output o_interamble_bits, 2, current DQS interamble symbol.

Function
REQ-013 Patterns SHALL be: 2tCK = 00,10; 3tCK = 00,00,10; 4tCK = 00,00,00,10; reserved sel treated as 2tCK; postamble 0.5tCK = 00; 1.5tCK = 10,00; interamble = 10 followed by the selected preamble pattern minus its first symbol (length = preamble length).
REQ-014 Selects SHALL be latched every enabled cycle while i_fsm_state is 000, 011 or 111, and held frozen while in 001 or 100; mid-pattern select changes SHALL be ignored.
REQ-015 Preamble symbol k SHALL be driven combinationally from the latched pattern and a symbol counter in the k-th enabled cycle of state 001, so symbol 0 is valid in the first preamble cycle (zero latency).
REQ-016 o_preamble_valid SHALL equal (i_fsm_state==001) and counter < length; counter SHALL saturate at length-1.
REQ-017 Each done output SHALL be high exactly in the cycle its last symbol is driven (counter == length-1 in the matching state), else low.
REQ-018 Counter SHALL clear on any enabled cycle whose state is not the pattern's state; leaving a state before done aborts the pattern with no done pulse.
REQ-019 Back-to-back entry (postamble directly to preamble, interamble to interamble via crc) SHALL restart from symbol 0.
REQ-020 Interamble SHALL run only if armed: arm flag set by i_interamble_valid in state 111, cleared on leaving state 100; unarmed state 100 SHALL drive 00 with o_interamble_done high in its first cycle.
REQ-021 Outside their states, o_preamble_bits and o_interamble_bits SHALL be 00 and done/valid outputs 0.
REQ-022 i_enable low SHALL hold counters, latches and arm flag; combinational outputs follow held state.

Reset
REQ-023 i_rst low SHALL asynchronously clear counters, arm flag, latched selects (00 / 0); all outputs SHALL then be 0.

Configuration
REQ-024 Macro DQS_PRE_4TCK_EN defined SHALL enable the 4tCK preamble (sel 10); undefined, sel 10 SHALL behave as 2tCK and PRE_MAX-sized storage MAY shrink to 3.

Structure
REQ-025 Package dqs_pattern_pkg SHALL hold FSM state code constants, preamble/postamble/interamble pattern constants and length constants.
REQ-026 One sub-module dqs_sym_shifter (loadable symbol register plus saturating counter, length and done logic) SHALL be instantiated three times (preamble, postamble, interamble).

Verification
REQ-027 sel=00, state 000->001 for 2 cycles -> bits 00,10; valid 1,1; o_preamble_done 0,1.
REQ-028 sel=01 latched, sel changed to 00 in preamble cycle 1 -> bits 00,00,10, done in cycle 3 only.
REQ-029 postamble_sel=1, state 011 two cycles then 001 -> bits 10,00, o_postamble_done in cycle 2, preamble restarts at symbol 0.
REQ-030 state 111 with i_interamble_valid=1, then 100 with sel=01 -> interamble 10,00,10, done in cycle 3; repeat without arm -> 00, done in cycle 1.
REQ-031 i_enable=0 during preamble cycle 2 of 4tCK -> symbol held for the stalled cycles; i_rst pulse mid-pattern -> all outputs 0 immediately, next entry starts at symbol 0.
REQ-032 Build without DQS_PRE_4TCK_EN, sel=10 -> 2-cycle pattern 00,10.
